sar_search16: RTL and testbench

SAR_SEARCH16 -- requirements
Module: sar_search16

---
 rtl/sar_search16.sv | 225 ++++++++++++++++++++++
 tb/tb_sar_search16.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sar_search16.sv
`default_nettype none
// ============================================================================
// Module      : sar_search16
// Description : Successive-approximation (binary) search over the signed
//               16-bit range. Drives a candidate value to an external signed
//               comparator and narrows [lo, hi] from its g/l/e response until
//               equality is found, the interval empties, or 17 samples are
//               taken.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   SETTLE   : 0..7 wait cycles between a probe update and its sample
// Ports
//   clk      : clock, all state on rising edge
//   rst_n    : asynchronous active-low reset
//   start    : one-cycle search request (honoured only in IDLE)
//   abort    : synchronous cancel of a running search (no done pulse)
//   g, l, e  : comparator response: probe >, <, == target
//   probe    : signed candidate driven to comparator input A
//   busy     : search in progress
//   done     : one-cycle completion pulse
//   found    : valid with done, 1 = equality reached
//   result   : matched value, held until overwritten by a later match
//   nprobes  : number of samples taken in the last search
//   err      : invalid comparator response (error-check build only)
// Build option
//   SAR_SEARCH_ERRCHK_EN : when defined, a non-one-hot {g,l,e} in a sample
//                          ends the search with err=1, found=0. When not
//                          defined err is tied 0 and responses resolve with
//                          priority e > g > l (000 counts as l).
// ============================================================================
module sar_search16 #(
    parameter int unsigned SETTLE = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic               g,
    input  logic               l,
    input  logic               e,
    output logic signed [15:0] probe,
    output logic               busy,
    output logic               done,
    output logic               found,
    output logic signed [15:0] result,
    output logic [4:0]         nprobes,
    output logic               err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Bounds are kept at 17 bits so that lo can step past 32767 and hi below
    // -32768, which is how an exhausted interval is detected.
    localparam logic signed [16:0] LO_INIT     = -17'sd32768;
    localparam logic signed [16:0] HI_INIT     = 17'sd32767;
    // (LO_INIT + HI_INIT) >>> 1 for the full range.
    localparam logic signed [15:0] FIRST_PROBE = -16'sd1;
    localparam logic [2:0]         SETTLE_LAST = (SETTLE == 0) ? 3'd0 : 3'(SETTLE - 1);
    localparam logic [4:0]         MAX_PROBES  = 5'd17;

    state_t                state_q;
    logic signed [16:0]    lo_q;
    logic signed [16:0]    hi_q;
    logic signed [15:0]    probe_q;
    logic [2:0]            settle_cnt_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  found_q;
    logic signed [15:0]    result_q;
    logic [4:0]            nprobes_q;

    logic signed [16:0]    probe_ext;
    logic                  take_g;
    logic signed [16:0]    lo_d;
    logic signed [16:0]    hi_d;
    logic [17:0]           sum_d;
    logic [15:0]           mid_d;
    logic                  empty_d;
    logic [4:0]            nprobes_d;
    logic                  unused_sum_bits;

    // Narrowed interval and next midpoint, evaluated from the live comparator
    // response; only consumed in SAMPLE.
    always_comb begin
        probe_ext = {probe_q[15], probe_q};
        // e dominates; with the error check enabled the response is one-hot
        // whenever this path is taken, so the same decode serves both builds.
        take_g    = ~e & g;
        if (take_g) begin
            lo_d = lo_q;
            hi_d = probe_ext - 17'sd1;
        end else begin
            lo_d = probe_ext + 17'sd1;
            hi_d = hi_q;
        end
        sum_d     = {lo_d[16], lo_d} + {hi_d[16], hi_d};
        // Arithmetic shift right by one; while lo <= hi the midpoint always
        // fits in 16 bits, so the top sum bit carries no information.
        mid_d     = sum_d[16:1];
        empty_d   = (lo_d > hi_d);
        nprobes_d = nprobes_q + 5'd1;
    end

    assign unused_sum_bits = ^{sum_d[17], sum_d[0]};

`ifdef SAR_SEARCH_ERRCHK_EN
    logic err_q;
    logic resp_bad;

    // Exactly one of g/l/e: odd parity but not all three.
    assign resp_bad = ~((g ^ l ^ e) & ~(g & l & e));
    assign err      = err_q;
`else
    assign err      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            lo_q         <= 17'sd0;
            hi_q         <= 17'sd0;
            probe_q      <= 16'sd0;
            settle_cnt_q <= 3'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            found_q      <= 1'b0;
            result_q     <= 16'sd0;
            nprobes_q    <= 5'd0;
`ifdef SAR_SEARCH_ERRCHK_EN
            err_q        <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    // A simultaneous abort cancels the request outright.
                    if (start && !abort) begin
                        lo_q         <= LO_INIT;
                        hi_q         <= HI_INIT;
                        probe_q      <= FIRST_PROBE;
                        nprobes_q    <= 5'd0;
                        busy_q       <= 1'b1;
                        settle_cnt_q <= 3'd0;
`ifdef SAR_SEARCH_ERRCHK_EN
                        err_q        <= 1'b0;
`endif
                        state_q      <= (SETTLE > 0) ? ST_SETTLE : ST_SAMPLE;
                    end
                end

                ST_SETTLE: begin
                    if (abort) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (settle_cnt_q == SETTLE_LAST) begin
                        state_q <= ST_SAMPLE;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + 3'd1;
                    end
                end

                ST_SAMPLE: begin
                    // Abort wins over whatever the comparator reports.
                    if (abort) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        nprobes_q <= nprobes_d;
`ifdef SAR_SEARCH_ERRCHK_EN
                        if (resp_bad) begin
                            err_q   <= 1'b1;
                            found_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else
`endif
                        if (e) begin
                            result_q <= probe_q;
                            found_q  <= 1'b1;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            state_q  <= ST_DONE;
                        end else if (empty_d || (nprobes_d == MAX_PROBES)) begin
                            found_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            lo_q         <= lo_d;
                            hi_q         <= hi_d;
                            probe_q      <= mid_d;
                            settle_cnt_q <= 3'd0;
                            state_q      <= (SETTLE > 0) ? ST_SETTLE : ST_SAMPLE;
                        end
                    end
                end

                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign probe   = probe_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign found   = found_q;
    assign result  = result_q;
    assign nprobes = nprobes_q;

endmodule
`default_nettype wire

// File: tb/tb_sar_search16.sv
`default_nettype none
// ============================================================================
// Module      : tb_sar_search16
// Description : Scoreboard bench for sar_search16. Two instances (SETTLE=0
//               and SETTLE=3) each talk to a behavioural signed comparator.
//               Stimulus pushes hand-computed completion records; per-DUT
//               monitors pop and compare on every done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sar_search16;

    typedef struct {
        logic               found;
        logic signed [15:0] result;
        logic [4:0]         nprobes;
        logic               err;
        bit                 chk_res;
    } exp_t;

`ifdef SAR_SEARCH_ERRCHK_EN
    localparam bit ERRCHK = 1'b1;
`else
    localparam bit ERRCHK = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic               start0, abort0, g0, l0, e0, busy0, done0, found0, err0;
    logic signed [15:0] probe0, result0;
    logic [4:0]         nprobes0;
    logic               start3, abort3, g3, l3, e3, busy3, done3, found3, err3;
    logic signed [15:0] probe3, result3;
    logic [4:0]         nprobes3;

    logic signed [15:0] tgt0, tgt3;
    int                 mode0, mode3;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t q0[$];
    exp_t q3[$];

    sar_search16 #(.SETTLE(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
        .g(g0), .l(l0), .e(e0), .probe(probe0), .busy(busy0), .done(done0),
        .found(found0), .result(result0), .nprobes(nprobes0), .err(err0)
    );

    sar_search16 #(.SETTLE(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3),
        .g(g3), .l(l3), .e(e3), .probe(probe3), .busy(busy3), .done(done3),
        .found(found3), .result(result3), .nprobes(nprobes3), .err(err3)
    );

    // Comparator models: mode 0 = true compare, 1 = g and l both high,
    // 2 = no response bit set.
    always_comb begin
        g0 = 1'b0; l0 = 1'b0; e0 = 1'b0;
        case (mode0)
            1:       begin g0 = 1'b1; l0 = 1'b1; end
            2:       begin end
            default: begin g0 = (probe0 > tgt0); l0 = (probe0 < tgt0); e0 = (probe0 == tgt0); end
        endcase
    end

    always_comb begin
        g3 = 1'b0; l3 = 1'b0; e3 = 1'b0;
        case (mode3)
            1:       begin g3 = 1'b1; l3 = 1'b1; end
            2:       begin end
            default: begin g3 = (probe3 > tgt3); l3 = (probe3 < tgt3); e3 = (probe3 == tgt3); end
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic f, input int r, input int n, input logic er, input bit c);
        exp_t x;
        x.found   = f;
        x.result  = 16'(r);
        x.nprobes = 5'(n);
        x.err     = er;
        x.chk_res = c;
        return x;
    endfunction

    task automatic mon_cmp(input string tag, input exp_t x, input logic fnd,
                           input logic signed [15:0] res, input logic [4:0] np,
                           input logic er, input logic bsy, input logic pdn);
        check({tag, " found"},   32'(fnd), 32'(x.found));
        check({tag, " nprobes"}, 32'(np),  32'(x.nprobes));
        check({tag, " err"},     32'(er),  32'(x.err));
        check({tag, " busy_at_done"}, 32'(bsy), 32'd0);
        check({tag, " done_width"},   32'(pdn), 32'd0);
        if (x.chk_res) check({tag, " result"}, 32'(res), 32'(x.result));
    endtask

    // ---------------- monitors ----------------
    logic pdone0 = 1'b0;
    logic pdone3 = 1'b0;

    always @(negedge clk) begin
        if (rst_n === 1'b1 && done0 === 1'b1) begin
            if (q0.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL d0 unexpected_done: got done=1 expected no pulse at %0t", $time);
            end else begin
                mon_cmp("d0", q0.pop_front(), found0, result0, nprobes0, err0, busy0, pdone0);
            end
        end
        pdone0 = done0;
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && done3 === 1'b1) begin
            if (q3.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL d3 unexpected_done: got done=1 expected no pulse at %0t", $time);
            end else begin
                mon_cmp("d3", q3.pop_front(), found3, result3, nprobes3, err3, busy3, pdone3);
            end
        end
        pdone3 = done3;
    end

    // Each probe on the SETTLE=3 instance must stay put for 4 busy cycles.
    bit                 hold_en = 1'b0;
    int                 hcnt    = 0;
    logic signed [15:0] hlast;

    always @(negedge clk) begin
        if (hold_en) begin
            if (!busy3) begin
                if (hcnt > 0) check("d3 probe_hold_last", 32'(hcnt), 32'd4);
                hcnt = 0;
            end else if (hcnt == 0) begin
                hcnt = 1; hlast = probe3;
            end else if (probe3 == hlast) begin
                hcnt++;
            end else begin
                check("d3 probe_hold", 32'(hcnt), 32'd4);
                hcnt = 1; hlast = probe3;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic pulse0(input logic ab);
        @(negedge clk); start0 = 1'b1; abort0 = ab;
        @(negedge clk); start0 = 1'b0; abort0 = 1'b0;
    endtask

    task automatic pulse3(input logic ab);
        @(negedge clk); start3 = 1'b1; abort3 = ab;
        @(negedge clk); start3 = 1'b0; abort3 = 1'b0;
    endtask

    task automatic wait_idle0();
        int n = 0;
        while ((busy0 || done0) && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) begin n_tests++; n_fail++; $display("FAIL d0 timeout: got busy after %0d cycles expected idle", n); end
    endtask

    task automatic wait_idle3();
        int n = 0;
        while ((busy3 || done3) && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) begin n_tests++; n_fail++; $display("FAIL d3 timeout: got busy after %0d cycles expected idle", n); end
    endtask

    task automatic run0(input int target, input exp_t x);
        tgt0 = 16'(target); mode0 = 0;
        q0.push_back(x);
        pulse0(1'b0);
        wait_idle0();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int n;
        rst_n = 1'b0;
        start0 = 1'b0; abort0 = 1'b0; start3 = 1'b0; abort3 = 1'b0;
        tgt0 = 16'sd0; tgt3 = 16'sd0; mode0 = 0; mode3 = 0;

        repeat (3) @(negedge clk);
        check("rst d0 probe",   32'(probe0),   32'd0);
        check("rst d0 busy",    32'(busy0),    32'd0);
        check("rst d0 done",    32'(done0),    32'd0);
        check("rst d0 found",   32'(found0),   32'd0);
        check("rst d0 result",  32'(result0),  32'd0);
        check("rst d0 nprobes", 32'(nprobes0), 32'd0);
        check("rst d0 err",     32'(err0),     32'd0);
        check("rst d3 busy",    32'(busy3),    32'd0);
        rst_n = 1'b1;

        // Target -1: first probe hits, done one cycle after the sample edge.
        tgt0 = -16'sd1; mode0 = 0;
        q0.push_back(mk(1'b1, -1, 1, 1'b0, 1'b1));
        pulse0(1'b0);
        check("t-1 busy",  32'(busy0),  32'd1);
        check("t-1 probe", 32'(probe0), 32'hFFFF_FFFF);
        check("t-1 done_early", 32'(done0), 32'd0);
        @(negedge clk);
        check("t-1 done", 32'(done0), 32'd1);
        wait_idle0();

        // Target 0: probe sequence -1, 16383, 8191 ... in 16 samples.
        tgt0 = 16'sd0;
        q0.push_back(mk(1'b1, 0, 16, 1'b0, 1'b1));
        pulse0(1'b0);
        check("t0 probe1", 32'(probe0), 32'hFFFF_FFFF);
        @(negedge clk);
        check("t0 probe2", 32'(probe0), 32'd16383);
        @(negedge clk);
        check("t0 probe3", 32'(probe0), 32'd8191);
        wait_idle0();

        // Range extremes.
        run0(-32768, mk(1'b1, -32768, 16, 1'b0, 1'b1));
        run0(32767,  mk(1'b1,  32767, 17, 1'b0, 1'b1));

        // start while busy is ignored: the sequence continues with 1023.
        tgt0 = 16'sd100;
        q0.push_back(mk(1'b1, 100, 16, 1'b0, 1'b1));
        pulse0(1'b0);
        repeat (4) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        check("busy_start probe", 32'(probe0), 32'd1023);
        check("busy_start busy",  32'(busy0),  32'd1);
        wait_idle0();

        // Invalid comparator responses.
        tgt0 = 16'sd0; mode0 = 1;
        q0.push_back(ERRCHK ? mk(1'b0, 0, 1, 1'b1, 1'b0) : mk(1'b0, 0, 16, 1'b0, 1'b0));
        pulse0(1'b0);
        wait_idle0();
        check("gl11 err_held", 32'(err0), 32'(ERRCHK));
        mode0 = 2;
        q0.push_back(ERRCHK ? mk(1'b0, 0, 1, 1'b1, 1'b0) : mk(1'b0, 0, 17, 1'b0, 1'b0));
        pulse0(1'b0);
        wait_idle0();
        // Next accepted start clears err.
        run0(5, mk(1'b1, 5, 15, 1'b0, 1'b1));
        check("err_cleared", 32'(err0), 32'd0);

        // start together with abort in IDLE stays idle.
        pulse0(1'b1);
        check("start_abort busy",  32'(busy0),  32'd0);
        check("start_abort probe", 32'(probe0), 32'd5);
        repeat (3) @(negedge clk);

        // SETTLE=3: abort on the third probe, then a clean restart.
        tgt3 = 16'sd100; mode3 = 0;
        pulse3(1'b0);
        n = 0;
        while (probe3 !== 16'sd8191 && n < 100) begin @(negedge clk); n++; end
        check("abort reached_probe3", 32'(probe3), 32'd8191);
        abort3 = 1'b1;
        @(negedge clk);
        abort3 = 1'b0;
        check("abort busy",   32'(busy3),   32'd0);
        check("abort done",   32'(done3),   32'd0);
        check("abort found",  32'(found3),  32'd0);
        check("abort result", 32'(result3), 32'd0);
        repeat (8) @(negedge clk);
        hold_en = 1'b1;
        q3.push_back(mk(1'b1, 100, 16, 1'b0, 1'b1));
        pulse3(1'b0);
        wait_idle3();
        @(negedge clk);
        hold_en = 1'b0;

        // Asynchronous reset in the middle of a search.
        tgt0 = 16'sd100; mode0 = 0;
        pulse0(1'b0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst busy",    32'(busy0),    32'd0);
        check("arst probe",   32'(probe0),   32'd0);
        check("arst result",  32'(result0),  32'd0);
        check("arst nprobes", 32'(nprobes0), 32'd0);
        check("arst found",   32'(found0),   32'd0);
        check("arst d3 result", 32'(result3), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run0(0, mk(1'b1, 0, 16, 1'b0, 1'b1));

        repeat (3) @(negedge clk);
        if (q0.size() != 0 || q3.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL missing_done: got %0d/%0d pending expected 0", q0.size(), q3.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish by 200000");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
